// File: rtl/pe_mem_arbiter_if.sv
// Purpose: bundles the PE-side request/grant signals and the shared memory read port.
// Latency: none, wires only.
// Backpressure: req is held until req_ack; memory side has no stall, mem_ack is a single-cycle response.
interface pe_mem_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        req_ack;
  logic [N_REQ-1:0]        req_err;
  logic [DATA_W-1:0]       req_rdata;
  logic                    mem_read;
  logic [ADDR_W-1:0]       mem_address;
  logic                    mem_ack;
  logic [DATA_W-1:0]       mem_data;
  logic                    busy;

  // Arbiter view: consumes requests and memory responses, drives grants and the read strobe.
  modport master (
    input  req, req_addr, mem_ack, mem_data,
    output gnt, req_ack, req_err, req_rdata, mem_read, mem_address, busy
  );

  // Environment view: the PE controllers plus the data memory.
  modport slave (
    output req, req_addr, mem_ack, mem_data,
    input  gnt, req_ack, req_err, req_rdata, mem_read, mem_address, busy
  );
endinterface

// File: rtl/pe_mem_arbiter.sv
// Purpose: round-robin share of one memory read port between N_REQ PE controllers.
// Latency: mem_read rises one edge after req is sampled; minimum 3 cycles per transaction.
// Backpressure: one transaction in flight; other PEs hold req until granted; WAIT ends on mem_ack or timeout.
module pe_mem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  pe_mem_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;

  // Round-robin pick: first requesting PE at or above the pointer, wrapping to 0.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!pick_vld && bus.req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/WAIT/DONE sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = ack_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    mem_read_d = mem_read_q;
    addr_d     = addr_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          mem_read_d      = 1'b1;
          addr_d          = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          cnt_d           = '0;
          state_d         = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the timeout cycle still counts as a good read.
        if (bus.mem_ack) begin
          rdata_d       = bus.mem_data;
          ack_d         = '0;
          ack_d[win_q]  = 1'b1;
          mem_read_d    = 1'b0;
          state_d       = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT-1))) begin
          rdata_d       = '0;
          ack_d         = '0;
          ack_d[win_q]  = 1'b1;
          err_d         = '0;
          err_d[win_q]  = 1'b1;
          mem_read_d    = 1'b0;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        // Holding gnt one extra cycle lets the PE drop req before we arbitrate again.
        ack_d   = '0;
        err_d   = '0;
        gnt_d   = '0;
        rdata_d = '0;
        if (win_q == IDX_W'(N_REQ-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + IDX_W'(1);
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously so a stuck transaction can always be aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      mem_read_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mem_read_q <= mem_read_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.req_ack     = ack_q;
  assign bus.req_err     = err_q;
  assign bus.req_rdata   = rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = addr_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Purpose: self-checking bench for pe_mem_arbiter, two instances with timeouts of 8 and 4 cycles.
// Latency: checks the one-edge grant latency and the 3-cycle minimum turnaround.
// Backpressure: the bench plays both the PEs (level req) and the memory (single-cycle mem_ack).
module tb_pe_mem_arbiter;

  typedef struct {
    logic [3:0]  ack;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  pe_mem_arbiter_if #(.N_REQ(4), .ADDR_W(32), .DATA_W(32)) bus_a ();
  pe_mem_arbiter_if #(.N_REQ(4), .ADDR_W(32), .DATA_W(32)) bus_b ();

  pe_mem_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pe_mem_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for instance A: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus_a.req_ack != 4'b0) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_ack", bus_a.req_ack, 4'b0);
      end else begin
        ea = q_a.pop_front();
        check("a_req_ack", bus_a.req_ack, ea.ack);
        check("a_req_err", bus_a.req_err, ea.err ? ea.ack : 4'b0);
        check("a_req_rdata", bus_a.req_rdata, ea.rdata);
        check("a_gnt_at_ack", bus_a.gnt, ea.ack);
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (!rst && bus_b.req_ack != 4'b0) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_ack", bus_b.req_ack, 4'b0);
      end else begin
        eb = q_b.pop_front();
        check("b_req_ack", bus_b.req_ack, eb.ack);
        check("b_req_err", bus_b.req_err, eb.err ? eb.ack : 4'b0);
        check("b_req_rdata", bus_b.req_rdata, eb.rdata);
        check("b_gnt_at_ack", bus_b.gnt, eb.ack);
      end
    end
  end

  // Serve one transaction on instance A. Called at a negedge with req already set for an idle DUT.
  task automatic serve_a(input int pe, input logic [31:0] addr, input int lat,
                         input logic [31:0] data, input bit to, input bit reraise);
    int         n;
    exp_t       e;
    logic [3:0] oh;
    oh = 4'b0001 << pe;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.mem_read && n < 20);
    check("grant_latency", n, 1);
    check("mem_read_seen", bus_a.mem_read, 1'b1);
    if (!bus_a.mem_read) return;
    check("gnt", bus_a.gnt, oh);
    check("mem_address", bus_a.mem_address, addr);
    check("busy_wait", bus_a.busy, 1'b1);
    e.ack   = oh;
    e.err   = to;
    e.rdata = to ? 32'h0 : data;
    q_a.push_back(e);
    bus_a.req_addr[pe*32 +: 32] = ~addr;
    if (to) begin
      n = 1;
      while (n < 40) begin
        @(negedge clk);
        if (!bus_a.mem_read) break;
        n++;
      end
      check("timeout_mem_read_cycles", n, 8);
    end else begin
      repeat (lat - 1) @(negedge clk);
      check("addr_hold", bus_a.mem_address, addr);
      bus_a.mem_ack  = 1'b1;
      bus_a.mem_data = data;
      @(negedge clk);
      bus_a.mem_ack  = 1'b0;
      bus_a.mem_data = 32'hBAD0_BAD0;
    end
    check("busy_done", bus_a.busy, 1'b1);
    bus_a.req[pe] = 1'b0;
    bus_a.req_addr[pe*32 +: 32] = addr;
    @(negedge clk);
    check("busy_idle", bus_a.busy, 1'b0);
    if (reraise) bus_a.req[pe] = 1'b1;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_a.req = '0; bus_a.req_addr = '0; bus_a.mem_ack = 1'b0; bus_a.mem_data = '0;
    bus_b.req = '0; bus_b.req_addr = '0; bus_b.mem_ack = 1'b0; bus_b.mem_data = '0;
    for (int i = 0; i < 4; i++) bus_a.req_addr[i*32 +: 32] = 32'h1000 + i*16;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", bus_a.gnt, 4'b0);
    check("rst_req_ack", bus_a.req_ack, 4'b0);
    check("rst_req_err", bus_a.req_err, 4'b0);
    check("rst_req_rdata", bus_a.req_rdata, 32'h0);
    check("rst_mem_read", bus_a.mem_read, 1'b0);
    check("rst_mem_address", bus_a.mem_address, 32'h0);
    check("rst_busy", bus_a.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from PE1 with a 2-cycle memory
    bus_a.req_addr[1*32 +: 32] = 32'h0000_0040;
    bus_a.req = 4'b0010;
    serve_a(1, 32'h0000_0040, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
    bus_a.req_addr[1*32 +: 32] = 32'h1010;

    // Reset mid-WAIT: pointer is now 2, so PE2 wins, then reset aborts it
    bus_a.req = 4'b0100;
    @(negedge clk);
    check("pre_rst_mem_read", bus_a.mem_read, 1'b1);
    check("pre_rst_gnt", bus_a.gnt, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_mem_read", bus_a.mem_read, 1'b0);
    check("rst_async_gnt", bus_a.gnt, 4'b0);
    check("rst_async_busy", bus_a.busy, 1'b0);
    bus_a.req = 4'b0;
    bus_a.mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_a.mem_ack = 1'b0;
    check("stale_ack_busy", bus_a.busy, 1'b0);
    check("stale_ack_req_ack", bus_a.req_ack, 4'b0);

    // Round-robin with all PEs requesting: pointer restarts at 0 after reset
    bus_a.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve_a(k % 4, 32'h1000 + (k % 4)*16, 1, 32'hD000_0000 + k, 1'b0, k < 4);
    end
    bus_a.req = 4'b0;

    // Pointer wrap: grant PE3, then with PE0 and PE3 requesting, PE0 goes first
    bus_a.req = 4'b1000;
    serve_a(3, 32'h1030, 1, 32'h3333_0003, 1'b0, 1'b0);
    bus_a.req = 4'b1001;
    serve_a(0, 32'h1000, 1, 32'h0000_A000, 1'b0, 1'b0);
    serve_a(3, 32'h1030, 3, 32'h0000_A003, 1'b0, 1'b0);
    bus_a.req = 4'b0;

    // Timeout on instance A: memory never answers
    bus_a.req = 4'b0100;
    serve_a(2, 32'h1020, 1, 32'h0, 1'b1, 1'b0);
    bus_a.mem_ack  = 1'b1;
    bus_a.mem_data = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_a.mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_busy", bus_a.busy, 1'b0);
    check("stray_ack_mem_read", bus_a.mem_read, 1'b0);
    check("stray_ack_req_ack", bus_a.req_ack, 4'b0);
    check("stray_ack_rdata", bus_a.req_rdata, 32'h0);

    // Instance B: mem_ack lands on the 4th WAIT cycle, the same cycle the timeout would fire
    bus_b.req_addr[31:0] = 32'h0000_2000;
    bus_b.req = 4'b0001;
    @(negedge clk);
    check("b_mem_read", bus_b.mem_read, 1'b1);
    check("b_gnt", bus_b.gnt, 4'b0001);
    eb.ack = 4'b0001; eb.rdata = 32'h0000_1234; eb.err = 1'b0;
    q_b.push_back(eb);
    repeat (3) @(negedge clk);
    check("b_mem_read_wait4", bus_b.mem_read, 1'b1);
    bus_b.mem_ack  = 1'b1;
    bus_b.mem_data = 32'h0000_1234;
    @(negedge clk);
    bus_b.mem_ack = 1'b0;
    bus_b.req = 4'b0;
    @(negedge clk);
    check("b_busy_idle", bus_b.busy, 1'b0);

    // Instance B: plain timeout after 4 cycles
    bus_b.req = 4'b0001;
    @(negedge clk);
    check("b_to_mem_read", bus_b.mem_read, 1'b1);
    eb.ack = 4'b0001; eb.rdata = 32'h0; eb.err = 1'b1;
    q_b.push_back(eb);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (!bus_b.mem_read) break;
      n++;
    end
    check("b_timeout_mem_read_cycles", n, 4);
    bus_b.req = 4'b0;
    @(negedge clk);
    @(negedge clk);

    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pe_mem_arbiter.md
Name: pe_mem_arbiter

Overview:
- Shares the single memory read port between N_REQ processing-element controllers in the CGRA array.
- Each PE controller raises a load request with an address. The arbiter grants one PE at a time using round-robin priority.
- While granted, it drives the memory handshake, returns the read data, and signals completion or timeout to that PE.
- Sits between the PE controllers' mem_read/mem_address/mem_ack interface and the shared data memory.

Parameters:
- N_REQ, 4, number of requesting PEs (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, maximum cycles spent waiting for mem_ack; 0 disables the timeout

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-PE level request; held high until that PE's req_ack
- req_addr  input  N_REQ*ADDR_W  flattened addresses; PE i occupies bits [i*ADDR_W +: ADDR_W]
- gnt  output  N_REQ  one-hot grant, registered
- req_ack  output  N_REQ  one-cycle completion pulse to the granted PE
- req_err  output  N_REQ  one-cycle timeout flag, coincident with req_ack
- req_rdata  output  DATA_W  read data, valid while req_ack is high
- mem_read  output  1  memory read strobe, registered
- mem_address  output  ADDR_W  latched address of the granted PE
- mem_ack  input  1  memory response valid; single-cycle
- mem_data  input  DATA_W  memory read data, valid with mem_ack
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0.
  - State goes to IDLE, the priority pointer to 0, and the timeout counter to 0.
  - Clocked operation resumes on the first edge after rst falls.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If req != 0, pick the winner: the first set bit scanning upward from the pointer index, wrapping N_REQ-1 to 0.
  - At the same edge: latch winner index and req_addr slice, set gnt[winner]=1, mem_read=1, mem_address=slice, counter=0, go to WAIT.
  - If req == 0, stay in IDLE.
  - Latency: req sampled high at edge k gives mem_read high after edge k.
- WAIT:
  - mem_read and mem_address are held constant.
  - Changes to req or req_addr are ignored.
  - The counter increments each cycle.
  - On mem_ack=1: latch mem_data into req_rdata, pulse req_ack[winner]=1, drop mem_read, go to DONE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: req_rdata=0, pulse req_ack[winner]=1 and req_err[winner]=1, drop mem_read, go to DONE.
  - If mem_ack and the timeout occur in the same cycle, mem_ack wins and no error is flagged.
- DONE (exactly one cycle):
  - req_ack/req_err are high during this cycle; gnt is still held.
  - At exit: clear req_ack, req_err, gnt and req_rdata to 0, set pointer = (winner+1) mod N_REQ, go to IDLE.
  - This cycle gives the PE time to drop req so it is not re-granted spuriously.
- Timing and fairness:
  - Minimum turnaround is 3 cycles per transaction (IDLE, WAIT, DONE) with a 1-cycle memory.
  - Round-robin bounds the wait of any continuously requesting PE to N_REQ-1 transactions.
- Ignored inputs:
  - mem_ack in IDLE or DONE has no effect; stale responses after reset or timeout are discarded.
  - A request whose bit drops before being granted is simply never selected; a request withdrawn while granted is still completed.
- Invariants: gnt, req_ack and req_err are each one-hot or zero; mem_read=1 only in WAIT.

Test Plan:
- Single request: req=4'b0010, req_addr[1]=0x0000_0040, mem_ack one cycle after mem_read with mem_data=0xCAFE_F00D. Expect:
  - mem_address=0x40;
  - gnt=4'b0010;
  - req_ack=4'b0010 for 1 cycle with req_rdata=0xCAFE_F00D and req_err=0;
  - busy back to 0 three cycles after the grant edge.
- Round-robin: req=4'b1111 held, re-raised after each ack. Expect grant order 0,1,2,3,0 and no PE granted twice before all others.
- Pointer wrap: after a PE3 grant, req=4'b1001. Expect PE0 granted next, then PE3.
- Timeout: TIMEOUT=8, mem_ack never asserted. Expect:
  - mem_read high for 8 cycles;
  - then req_ack=req_err=1 for the winner with req_rdata=0;
  - a later stray mem_ack in IDLE is ignored.
- Simultaneous ack and timeout: TIMEOUT=4, mem_ack on the 4th WAIT cycle with data 0x1234. Expect req_rdata=0x1234 and req_err=0.
- Reset mid-WAIT: assert rst between edges while mem_read=1. Expect mem_read, gnt and busy at 0 immediately; the next grant after release goes to PE0 first.
